// File: rtl/ex_stage_param.sv
// Parametrised execute stage with EX/MEM pipeline register, flag bypass and shifter.
// Define EX_MUL_EN to build the iterative shift-add multiplier (alu_ctrl 3'b001).

module ex_stage_param #(
    parameter int WIDTH  = 64,
    parameter int REG_AW = 5,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_in,
    input  logic [WIDTH-1:0]  d1,
    input  logic [WIDTH-1:0]  d2,
    input  logic [WIDTH-1:0]  mem_in,
    input  logic [SHW-1:0]    shamt,
    input  logic              shift_dir,
    input  logic              shift_sel,
    input  logic [2:0]        alu_ctrl,
    input  logic              flag_en,
    input  logic [REG_AW-1:0] wr_reg_in,
    input  logic              mem_write_in,
    input  logic              mem_read_in,
    input  logic              mem_to_reg_in,
    input  logic              reg_write_in,
    input  logic              stall,
    input  logic              flush,
    output logic [WIDTH-1:0]  exec_out,
    output logic [WIDTH-1:0]  mem_out,
    output logic [REG_AW-1:0] wr_reg_out,
    output logic              mem_write_out,
    output logic              mem_read_out,
    output logic              mem_to_reg_out,
    output logic              reg_write_out,
    output logic              valid_out,
    output logic [WIDTH-1:0]  exec_fwd,
    output logic [REG_AW-1:0] wr_reg_fwd,
    output logic              flag_n,
    output logic              flag_z,
    output logic              flag_v,
    output logic              flag_c,
    output logic              cond_n,
    output logic              cond_v,
    output logic              ex_busy
);

    logic [WIDTH-1:0]  w_alu, w_shift, w_exec, w_prod;
    logic [WIDTH:0]    w_sum, w_dif;
    logic              w_alu_c, w_alu_v, w_new_c, w_new_v;
    logic              w_busy, w_mul_done;
    logic [WIDTH-1:0]  r_exec, r_mem;
    logic [REG_AW-1:0] r_wr;
    logic              r_mw, r_mr, r_m2r, r_rw, r_valid;
    logic              r_n, r_z, r_v, r_c;

    assign w_sum = {1'b0, d1} + {1'b0, d2};
    assign w_dif = {1'b0, d1} - {1'b0, d2};

    // ALU; subtract carry uses the no-borrow convention
    always_comb begin
        w_alu   = {WIDTH{1'b0}};
        w_alu_c = 1'b0;
        w_alu_v = 1'b0;
        case (alu_ctrl)
            3'b000: w_alu = d2;
            3'b010: begin
                w_alu   = w_sum[WIDTH-1:0];
                w_alu_c = w_sum[WIDTH];
                w_alu_v = (d1[WIDTH-1] == d2[WIDTH-1]) && (w_sum[WIDTH-1] != d1[WIDTH-1]);
            end
            3'b011: begin
                w_alu   = w_dif[WIDTH-1:0];
                w_alu_c = ~w_dif[WIDTH];
                w_alu_v = (d1[WIDTH-1] != d2[WIDTH-1]) && (w_dif[WIDTH-1] != d1[WIDTH-1]);
            end
            3'b100:  w_alu = d1 & d2;
            3'b101:  w_alu = d1 | d2;
            3'b110:  w_alu = d1 ^ d2;
            default: w_alu = {WIDTH{1'b0}};
        endcase
    end

    assign w_shift = shift_dir ? (d1 << shamt) : (d1 >> shamt);

    // Result source: finished product, shifter or ALU
    always_comb begin
        if (w_mul_done) begin
            w_exec  = w_prod;
            w_new_c = 1'b0;
            w_new_v = 1'b0;
        end else if (shift_sel) begin
            w_exec  = w_shift;
            w_new_c = 1'b0;
            w_new_v = 1'b0;
        end else begin
            w_exec  = w_alu;
            w_new_c = w_alu_c;
            w_new_v = w_alu_v;
        end
    end

`ifdef EX_MUL_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DONE = 2'd2} state_t;
    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_mcand, r_mplier, r_prod;
    logic [SHW-1:0]   r_cnt;
    logic             w_start;

    assign w_start = valid_in && (alu_ctrl == 3'b001) && !flush;

    // Multiplier state register
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Multiplier next state; DONE waits out a downstream stall so the product is not lost
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_next = S_MUL; else w_next = S_IDLE;
            S_MUL:   if (flush) w_next = S_IDLE;
                     else if (r_cnt == SHW'(WIDTH - 1)) w_next = S_DONE;
                     else w_next = S_MUL;
            S_DONE:  if (flush || !stall) w_next = S_IDLE; else w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    // Multiplier outputs
    always_comb begin
        w_busy     = 1'b0;
        w_mul_done = 1'b0;
        case (r_state)
            S_IDLE:  w_busy = w_start;
            S_MUL:   w_busy = 1'b1;
            S_DONE:  w_mul_done = 1'b1;
            default: w_busy = 1'b0;
        endcase
    end

    // Shift-add datapath: one multiplier bit per MUL cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mcand  <= {WIDTH{1'b0}};
            r_mplier <= {WIDTH{1'b0}};
            r_prod   <= {WIDTH{1'b0}};
            r_cnt    <= {SHW{1'b0}};
        end else if (r_state == S_IDLE && w_start) begin
            r_mcand  <= d1;
            r_mplier <= d2;
            r_prod   <= {WIDTH{1'b0}};
            r_cnt    <= {SHW{1'b0}};
        end else if (r_state == S_MUL) begin
            r_prod   <= r_prod + (r_mplier[0] ? r_mcand : {WIDTH{1'b0}});
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + {{(SHW-1){1'b0}}, 1'b1};
        end
    end

    assign w_prod = r_prod;
`else
    assign w_busy     = 1'b0;
    assign w_mul_done = 1'b0;
    assign w_prod     = {WIDTH{1'b0}};
`endif

    // EX/MEM register and flags: reset > flush > hold > capture
    always_ff @(posedge clk) begin
        if (reset) begin
            r_exec <= {WIDTH{1'b0}};
            r_mem  <= {WIDTH{1'b0}};
            r_wr   <= {REG_AW{1'b0}};
            r_mw   <= 1'b0;
            r_mr   <= 1'b0;
            r_m2r  <= 1'b0;
            r_rw   <= 1'b0;
            r_valid <= 1'b0;
            r_n <= 1'b0;
            r_z <= 1'b0;
            r_v <= 1'b0;
            r_c <= 1'b0;
        end else if (flush) begin
            r_exec <= {WIDTH{1'b0}};
            r_mem  <= {WIDTH{1'b0}};
            r_wr   <= {REG_AW{1'b0}};
            r_mw   <= 1'b0;
            r_mr   <= 1'b0;
            r_m2r  <= 1'b0;
            r_rw   <= 1'b0;
            r_valid <= 1'b0;
        end else if (!(stall || w_busy)) begin
            r_exec  <= w_exec;
            r_mem   <= mem_in;
            r_wr    <= wr_reg_in;
            r_mw    <= mem_write_in;
            r_mr    <= mem_read_in;
            r_m2r   <= mem_to_reg_in;
            r_rw    <= reg_write_in;
            r_valid <= valid_in;
            if (valid_in && flag_en) begin
                r_n <= w_exec[WIDTH-1];
                r_z <= (w_exec == {WIDTH{1'b0}});
                r_v <= w_new_v;
                r_c <= w_new_c;
            end
        end
    end

    assign exec_out       = r_exec;
    assign mem_out        = r_mem;
    assign wr_reg_out     = r_wr;
    assign mem_write_out  = r_mw;
    assign mem_read_out   = r_mr;
    assign mem_to_reg_out = r_m2r;
    assign reg_write_out  = r_rw;
    assign valid_out      = r_valid;
    assign flag_n         = r_n;
    assign flag_z         = r_z;
    assign flag_v         = r_v;
    assign flag_c         = r_c;
    assign exec_fwd       = w_exec;
    assign wr_reg_fwd     = (valid_in && reg_write_in) ? wr_reg_in : {REG_AW{1'b0}};
    assign cond_n         = (flag_en && valid_in) ? w_exec[WIDTH-1] : r_n;
    assign cond_v         = (flag_en && valid_in) ? w_new_v : r_v;
    assign ex_busy        = w_busy;

endmodule

// File: tb/tb_ex_stage_param.sv
// Randomised bench for ex_stage_param (WIDTH=64) against an arithmetic reference model.
// Multiplier checks are built only when EX_MUL_EN is defined.

module tb_ex_stage_param;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, valid_in, shift_dir, shift_sel, flag_en, stall, flush;
    logic        mem_write_in, mem_read_in, mem_to_reg_in, reg_write_in;
    logic [63:0] d1, d2, mem_in;
    logic [5:0]  shamt;
    logic [2:0]  alu_ctrl;
    logic [4:0]  wr_reg_in;
    logic [63:0] exec_out, mem_out, exec_fwd;
    logic [4:0]  wr_reg_out, wr_reg_fwd;
    logic        mem_write_out, mem_read_out, mem_to_reg_out, reg_write_out, valid_out;
    logic        flag_n, flag_z, flag_v, flag_c, cond_n, cond_v, ex_busy;

    ex_stage_param #(.WIDTH(64), .REG_AW(5)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .d1(d1), .d2(d2), .mem_in(mem_in),
        .shamt(shamt), .shift_dir(shift_dir), .shift_sel(shift_sel), .alu_ctrl(alu_ctrl),
        .flag_en(flag_en), .wr_reg_in(wr_reg_in), .mem_write_in(mem_write_in),
        .mem_read_in(mem_read_in), .mem_to_reg_in(mem_to_reg_in), .reg_write_in(reg_write_in),
        .stall(stall), .flush(flush), .exec_out(exec_out), .mem_out(mem_out),
        .wr_reg_out(wr_reg_out), .mem_write_out(mem_write_out), .mem_read_out(mem_read_out),
        .mem_to_reg_out(mem_to_reg_out), .reg_write_out(reg_write_out), .valid_out(valid_out),
        .exec_fwd(exec_fwd), .wr_reg_fwd(wr_reg_fwd), .flag_n(flag_n), .flag_z(flag_z),
        .flag_v(flag_v), .flag_c(flag_c), .cond_n(cond_n), .cond_v(cond_v), .ex_busy(ex_busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference copy of the EX/MEM register contents and flags
    logic [63:0] m_exec, m_mem;
    logic [4:0]  m_wr;
    logic        m_mw, m_mr, m_m2r, m_rw, m_valid, m_n, m_z, m_c, m_v;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Result and c/v from the instruction semantics (true signed result vs truncated)
    function automatic void ref_exec(output logic [63:0] res, output logic c, output logic v);
        logic signed [65:0] t;
        res = 64'd0; c = 1'b0; v = 1'b0;
        if (shift_sel) begin
            res = shift_dir ? (d1 << shamt) : (d1 >> shamt);
        end else begin
            case (alu_ctrl)
                3'b000: res = d2;
                3'b010: begin
                    res = d1 + d2;
                    c = (res < d1);
                    t = $signed(d1) + $signed(d2);
                    v = (t != $signed({{2{res[63]}}, res}));
                end
                3'b011: begin
                    res = d1 - d2;
                    c = (d1 >= d2);
                    t = $signed(d1) - $signed(d2);
                    v = (t != $signed({{2{res[63]}}, res}));
                end
                3'b100: res = d1 & d2;
                3'b101: res = d1 | d2;
                3'b110: res = d1 ^ d2;
                default: res = 64'd0;
            endcase
        end
    endfunction

    task automatic idle_inputs();
        reset = 1'b0; valid_in = 1'b0; shift_dir = 1'b0; shift_sel = 1'b0; flag_en = 1'b0;
        stall = 1'b0; flush = 1'b0; mem_write_in = 1'b0; mem_read_in = 1'b0;
        mem_to_reg_in = 1'b0; reg_write_in = 1'b0; d1 = 64'd0; d2 = 64'd0; mem_in = 64'd0;
        shamt = 6'd0; alu_ctrl = 3'b000; wr_reg_in = 5'd0;
    endtask

    // One clock: check combinational outputs, advance the model, check registered outputs
    task automatic cycle();
        logic [63:0] r;
        logic c, v;
        @(negedge clk);
        ref_exec(r, c, v);
        check("exec_fwd", exec_fwd, r);
        check("wr_reg_fwd", {59'd0, wr_reg_fwd}, (valid_in && reg_write_in) ? {59'd0, wr_reg_in} : 64'd0);
        check("cond_n", {63'd0, cond_n}, {63'd0, (flag_en && valid_in) ? r[63] : m_n});
        check("cond_v", {63'd0, cond_v}, {63'd0, (flag_en && valid_in) ? v : m_v});
        check("ex_busy", {63'd0, ex_busy}, 64'd0);
        if (reset) begin
            m_exec = 64'd0; m_mem = 64'd0; m_wr = 5'd0; m_mw = 1'b0; m_mr = 1'b0; m_m2r = 1'b0;
            m_rw = 1'b0; m_valid = 1'b0; m_n = 1'b0; m_z = 1'b0; m_c = 1'b0; m_v = 1'b0;
        end else if (flush) begin
            m_exec = 64'd0; m_mem = 64'd0; m_wr = 5'd0; m_mw = 1'b0; m_mr = 1'b0; m_m2r = 1'b0;
            m_rw = 1'b0; m_valid = 1'b0;
        end else if (!stall) begin
            m_exec = r; m_mem = mem_in; m_wr = wr_reg_in; m_mw = mem_write_in; m_mr = mem_read_in;
            m_m2r = mem_to_reg_in; m_rw = reg_write_in; m_valid = valid_in;
            if (valid_in && flag_en) begin
                m_n = r[63]; m_z = (r == 64'd0); m_c = c; m_v = v;
            end
        end
        @(posedge clk);
        #1;
        check("exec_out", exec_out, m_exec);
        check("mem_out", mem_out, m_mem);
        check("wr_reg_out", {59'd0, wr_reg_out}, {59'd0, m_wr});
        check("ctrl_out", {59'd0, valid_out, mem_write_out, mem_read_out, mem_to_reg_out, reg_write_out},
              {59'd0, m_valid, m_mw, m_mr, m_m2r, m_rw});
        check("flags", {60'd0, flag_n, flag_z, flag_c, flag_v}, {60'd0, m_n, m_z, m_c, m_v});
    endtask

    initial begin
        idle_inputs();
        m_exec = 64'd0; m_mem = 64'd0; m_wr = 5'd0; m_mw = 1'b0; m_mr = 1'b0; m_m2r = 1'b0;
        m_rw = 1'b0; m_valid = 1'b0; m_n = 1'b0; m_z = 1'b0; m_c = 1'b0; m_v = 1'b0;
        @(posedge clk); #1;

        // Reset state
        reset = 1'b1; cycle(); reset = 1'b0;
        check("rst_exec_out", exec_out, 64'd0);
        check("rst_valid_flags", {59'd0, valid_out, flag_n, flag_z, flag_c, flag_v}, 64'd0);

        // Signed overflow on add, with same-cycle bypass of v
        valid_in = 1'b1; alu_ctrl = 3'b010; flag_en = 1'b1;
        d1 = 64'h7FFF_FFFF_FFFF_FFFF; d2 = 64'd1;
        #1 check("lit_cond_v_bypass", {63'd0, cond_v}, 64'd1);
        cycle();
        check("lit_add_exec", exec_out, 64'h8000_0000_0000_0000);
        check("lit_add_nzcv", {60'd0, flag_n, flag_z, flag_c, flag_v}, 64'b1001);

        // Sub equal operands, then a non-flag AND must retain z=1,c=1
        alu_ctrl = 3'b011; d1 = 64'd5; d2 = 64'd5; cycle();
        alu_ctrl = 3'b100; flag_en = 1'b0; d1 = 64'd3; d2 = 64'd12; cycle();
        check("lit_sub_zc_kept", {62'd0, flag_z, flag_c}, 64'b11);
        check("lit_and_exec", exec_out, 64'd0);

        // Shift boundaries
        shift_sel = 1'b1; shift_dir = 1'b1; d1 = 64'd1; shamt = 6'd63; cycle();
        check("lit_shl63", exec_out, 64'h8000_0000_0000_0000);
        shift_dir = 1'b0; cycle();
        check("lit_shr63", exec_out, 64'd0);
        shift_sel = 1'b0;

        // Store captured, then frozen through a 3-cycle stall
        alu_ctrl = 3'b000; d2 = 64'h1000; mem_in = 64'hDEAD_BEEF; mem_write_in = 1'b1; cycle();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            d2 = {$urandom, $urandom}; mem_in = {$urandom, $urandom}; valid_in = 1'($urandom);
            cycle();
            check("lit_stall_exec", exec_out, 64'h1000);
            check("lit_stall_mem", mem_out, 64'hDEAD_BEEF);
        end
        valid_in = 1'b1; flag_en = 1'b1; flush = 1'b1; cycle();
        check("lit_flush_ctrl", {62'd0, valid_out, mem_write_out}, 64'd0);
        check("lit_flush_flags", {60'd0, flag_n, flag_z, flag_c, flag_v}, 64'b0110);
        stall = 1'b0; flush = 1'b0; flag_en = 1'b0; mem_write_in = 1'b0;

        // Forwarded destination and reset mid-stream
        reg_write_in = 1'b1; wr_reg_in = 5'd7; valid_in = 1'b1;
        #1 check("lit_wr_fwd_valid", {59'd0, wr_reg_fwd}, 64'd7);
        valid_in = 1'b0;
        #1 check("lit_wr_fwd_invalid", {59'd0, wr_reg_fwd}, 64'd0);
        valid_in = 1'b1; d2 = 64'h55; cycle();
        reset = 1'b1; cycle(); reset = 1'b0;
        check("lit_midrst", {54'd0, wr_reg_out, valid_out, reg_write_out, flag_z, flag_c, flag_n}, 64'd0);
        check("lit_midrst_exec", exec_out, 64'd0);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 63) == 0);
            flush = ($urandom_range(0, 9) == 0);
            stall = ($urandom_range(0, 4) == 0);
            valid_in = ($urandom_range(0, 5) != 0);
            flag_en = 1'($urandom); shift_sel = ($urandom_range(0, 3) == 0); shift_dir = 1'($urandom);
            d1 = {$urandom, $urandom}; d2 = {$urandom, $urandom}; mem_in = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) d2 = d1;
            if ($urandom_range(0, 7) == 0) d1 = 64'h7FFF_FFFF_FFFF_FFFF;
            shamt = 6'($urandom); wr_reg_in = 5'($urandom);
            mem_write_in = 1'($urandom); mem_read_in = 1'($urandom);
            mem_to_reg_in = 1'($urandom); reg_write_in = 1'($urandom);
`ifdef EX_MUL_EN
            do alu_ctrl = 3'($urandom); while (alu_ctrl == 3'b001);
`else
            alu_ctrl = 3'($urandom);
`endif
            cycle();
        end

        idle_inputs();
        reset = 1'b1; cycle(); reset = 1'b0;

`ifdef EX_MUL_EN
        begin
            int edges, busy_cnt;
            bit got;
            edges = 0; busy_cnt = 0; got = 1'b0;
            valid_in = 1'b1; alu_ctrl = 3'b001; flag_en = 1'b1; reg_write_in = 1'b1; wr_reg_in = 5'd3;
            d1 = 64'd12345; d2 = 64'hFFFF_FFFF_FFFF_FFFD;
            #1 check("mul_start_busy", {63'd0, ex_busy}, 64'd1);
            for (int k = 1; k <= 200 && !got; k++) begin
                @(posedge clk); #1;
                edges = k;
                d1 = {$urandom, $urandom}; d2 = {$urandom, $urandom};
                if (valid_out) got = 1'b1;
                else if (ex_busy) busy_cnt++;
            end
            check("mul_latency", 64'(edges - 1), 64'd65);
            check("mul_busy_cycles", 64'(busy_cnt), 64'd64);
            check("mul_product", exec_out, 64'hFFFF_FFFF_FFFF_6F55);
            check("mul_flags", {60'd0, flag_n, flag_z, flag_c, flag_v}, 64'b1000);
            check("mul_wr_reg", {59'd0, wr_reg_out}, 64'd3);

            // Flush aborts an in-flight multiply
            d1 = 64'd7; d2 = 64'd9;
            for (int k = 0; k < 10; k++) begin
                @(posedge clk); #1;
            end
            check("mul_busy_before_flush", {63'd0, ex_busy}, 64'd1);
            flush = 1'b1;
            @(posedge clk); #1;
            check("mul_flush_busy", {63'd0, ex_busy}, 64'd0);
            check("mul_flush_valid", {63'd0, valid_out}, 64'd0);
            flush = 1'b0; valid_in = 1'b0;
            for (int k = 0; k < 3; k++) begin
                @(posedge clk); #1;
                check("mul_after_flush", {62'd0, ex_busy, valid_out}, 64'd0);
            end
        end
`else
        valid_in = 1'b1; alu_ctrl = 3'b001; d1 = 64'd12345; d2 = 64'd3;
        #1 check("nomul_busy", {63'd0, ex_busy}, 64'd0);
        check("nomul_fwd", exec_fwd, 64'd0);
        cycle();
        check("nomul_exec", exec_out, 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
